// File: rtl/shared_ram_pkg.sv
// Shared types and constants for the multi-port shared data RAM.
// Build option: SHARED_RAM_ATOMIC_EN enables LR/SC reservation tracking.
package shared_ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Store-conditional status returned on the read data bus.
  localparam logic SC_OK   = 1'b0;
  localparam logic SC_FAIL = 1'b1;

  // Bits needed to index n items (at least one bit so vectors stay legal).
  function automatic int idx_bits(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/shared_data_ram_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr (mod N_PORTS)
// and grants the first requester. The pointer register lives in the parent.
module rr_arbiter
  import shared_ram_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] cand_s;

  // First requester at or above ptr, wrapping around, wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_s    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand_s = IDX_W'((int'(ptr) + i) % N_PORTS);
      if (!grant_any && req[cand_s]) begin
        grant_any     = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/shared_data_ram.sv
// Multi-port shared data RAM with round-robin arbitration, LATENCY wait
// cycles per access and optional LR/SC reservations.
// Build option: define SHARED_RAM_ATOMIC_EN to enable per-port reservations;
// without it mem_atomic is ignored and STORE_A behaves as a plain store.
module shared_data_ram
  import shared_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int N_PORTS = 2,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_PORTS*ADDR_W-1:0]   mem_addr,
  input  logic [N_PORTS*DATA_W-1:0]   mem_data_w,
  input  logic [N_PORTS-1:0]          mem_read,
  input  logic [N_PORTS-1:0]          mem_write,
  input  logic [N_PORTS-1:0]          mem_atomic,
  output logic [N_PORTS*DATA_W-1:0]   mem_data_r,
  output logic [N_PORTS-1:0]          mem_wait
);

  localparam int IDX_W  = idx_bits(N_PORTS);
  localparam int CNT_W  = idx_bits(LATENCY);
  localparam int MEM_AW = idx_bits(DEPTH);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   gnt_idx_r;
  logic [N_PORTS-1:0] gnt_oh_r;

  logic [N_PORTS-1:0] req_s;
  logic [N_PORTS-1:0] arb_grant_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_any_s;

  logic [ADDR_W-1:0]  gnt_addr_s;
  logic [DATA_W-1:0]  gnt_wdata_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic               gnt_req_s;
  logic               is_write_s;
  logic               in_range_s;
  logic               complete_s;
  logic               sc_fail_s;
  logic               wr_en_s;

  logic [DATA_W-1:0]  mem_r [DEPTH];

  // A write wins when read and write are both raised.
  assign req_s = mem_read | mem_write;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_s),
    .ptr       (ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .grant_any (arb_any_s)
  );

  // Select the granted port's request fields.
  always_comb begin
    gnt_addr_s  = mem_addr[int'(gnt_idx_r)*ADDR_W +: ADDR_W];
    gnt_wdata_s = mem_data_w[int'(gnt_idx_r)*DATA_W +: DATA_W];
    gnt_req_s   = req_s[gnt_idx_r];
    is_write_s  = mem_write[gnt_idx_r];
    in_range_s  = (gnt_addr_s < ADDR_W'(DEPTH));
  end

  // The access completes on the last BUSY cycle only while enabled and
  // while the granted port still holds its request.
  assign complete_s = en & (state_r == ST_BUSY) & gnt_req_s & (cnt_r == '0);

  // Asynchronous array read; out-of-range addresses read as zero.
  always_comb begin
    rd_data_s = '0;
    if (in_range_s) begin
      rd_data_s = mem_r[gnt_addr_s[MEM_AW-1:0]];
    end else begin
      rd_data_s = '0;
    end
  end

`ifdef SHARED_RAM_ATOMIC_EN
  logic [N_PORTS-1:0] resv_valid_r;
  logic [ADDR_W-1:0]  resv_addr_r [N_PORTS];
  logic               atomic_s;
  logic               own_match_s;

  assign atomic_s    = mem_atomic[gnt_idx_r];
  assign own_match_s = resv_valid_r[gnt_idx_r] & (resv_addr_r[gnt_idx_r] == gnt_addr_s);
  assign sc_fail_s   = atomic_s & is_write_s & ~own_match_s;

  // Reservation table: LOAD_A sets, STORE_A clears its own, committed
  // writes snoop-clear every matching reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_valid_r <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        resv_addr_r[p] <= '0;
      end
    end else if (complete_s) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (is_write_s && !sc_fail_s && resv_valid_r[p] && (resv_addr_r[p] == gnt_addr_s)) begin
          resv_valid_r[p] <= 1'b0;
        end
      end
      if (atomic_s && is_write_s) begin
        resv_valid_r[gnt_idx_r] <= 1'b0;
      end else if (atomic_s) begin
        resv_valid_r[gnt_idx_r] <= 1'b1;
        resv_addr_r[gnt_idx_r]  <= gnt_addr_s;
      end
    end
  end
`else
  logic unused_atomic_s;
  assign unused_atomic_s = ^mem_atomic;
  assign sc_fail_s       = 1'b0;
`endif

  assign wr_en_s = complete_s & is_write_s & in_range_s & ~sc_fail_s;

  // Memory array write at the edge ending the completion cycle; not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[gnt_addr_s[MEM_AW-1:0]] <= gnt_wdata_s;
    end
  end

  // Arbitration FSM: IDLE grants, BUSY counts down, then completes or aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      ptr_r     <= '0;
      gnt_idx_r <= '0;
      gnt_oh_r  <= '0;
    end else if (en) begin
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s) begin
            state_r   <= ST_BUSY;
            cnt_r     <= CNT_W'(LATENCY - 1);
            gnt_idx_r <= arb_idx_s;
            gnt_oh_r  <= arb_grant_s;
            ptr_r     <= (arb_idx_s == IDX_W'(N_PORTS - 1)) ? '0 : arb_idx_s + IDX_W'(1);
          end
        end
        ST_BUSY: begin
          if (!gnt_req_s) begin
            state_r <= ST_IDLE;
          end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Wait is request minus completion; data is driven only for the
  // completing port (read data or store-conditional status).
  always_comb begin
    mem_data_r = '0;
    mem_wait   = req_s;
    if (complete_s) begin
      mem_wait = req_s & ~gnt_oh_r;
      if (is_write_s) begin
        mem_data_r[int'(gnt_idx_r)*DATA_W +: DATA_W] = DATA_W'(sc_fail_s ? SC_FAIL : SC_OK);
      end else begin
        mem_data_r[int'(gnt_idx_r)*DATA_W +: DATA_W] = rd_data_s;
      end
    end else begin
      mem_wait   = req_s;
      mem_data_r = '0;
    end
  end

endmodule

// File: tb/tb_shared_data_ram.sv
// Scoreboard bench for shared_data_ram: a single-port LATENCY=1 instance and
// a two-port LATENCY=3 instance, driven with directed accesses.
module tb_shared_data_ram;

  localparam int DEPTH = 256;

`ifdef SHARED_RAM_ATOMIC_EN
  localparam logic [31:0] SC_BREAK_RET = 32'd1;
  localparam logic [31:0] MEM200_EXP   = 32'd9;
`else
  localparam logic [31:0] SC_BREAK_RET = 32'd0;
  localparam logic [31:0] MEM200_EXP   = 32'd7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [0:0]  a_read, a_write, a_atomic, a_wait;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_read, b_write, b_atomic, b_wait;

  shared_data_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .N_PORTS(1), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .mem_addr(a_addr), .mem_data_w(a_wdata),
    .mem_read(a_read), .mem_write(a_write), .mem_atomic(a_atomic),
    .mem_data_r(a_rdata), .mem_wait(a_wait)
  );

  shared_data_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .N_PORTS(2), .LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .mem_addr(b_addr), .mem_data_w(b_wdata),
    .mem_read(b_read), .mem_write(b_write), .mem_atomic(b_atomic),
    .mem_data_r(b_rdata), .mem_wait(b_wait)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push_exp(input int ch, input exp_t e);
    case (ch)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic logic wait_of(input int ch);
    case (ch)
      0: return a_wait[0];
      1: return b_wait[0];
      default: return b_wait[1];
    endcase
  endfunction

  task automatic drive(input int ch, input logic rd, input logic wr, input logic at,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int p;
    p = ch - 1;
    if (ch == 0) begin
      a_read[0] = rd; a_write[0] = wr; a_atomic[0] = at;
      a_addr = addr;  a_wdata = wdata;
    end else begin
      b_read[p] = rd; b_write[p] = wr; b_atomic[p] = at;
      b_addr[p*32 +: 32] = addr;
      b_wdata[p*32 +: 32] = wdata;
    end
  endtask

  // Issue one access, record its expected data and completion cycle,
  // hold the request until completion, then drop it.
  task automatic access(input string name, input int ch, input logic wr, input logic at,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int lat);
    exp_t e;
    int   n;
    e.data = exp_data;
    e.cyc  = cyc + lat;
    e.name = name;
    push_exp(ch, e);
    drive(ch, !wr, wr, at, addr, wdata);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wait_of(ch) && n < 64);
    if (wait_of(ch)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no completion within %0d cycles", name, n);
    end
    @(posedge clk);
    #1;
    drive(ch, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_pop(input int ch, input logic [31:0] data);
    exp_t e;
    logic got;
    got = 1'b0;
    case (ch)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL unexpected_completion ch%0d: data=%h cycle=%0d, none expected", ch, data, cyc);
    end else if (data !== e.data || cyc != e.cyc) begin
      n_fail++;
      $display("FAIL %s: data=%h cycle=%0d, expected data=%h cycle=%0d", e.name, data, cyc, e.data, e.cyc);
    end
  endtask

  task automatic check_zero(input string name, input logic [31:0] data);
    n_checks++;
    if (data !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: data=%h outside completion, expected 0 at cycle %0d", name, data, cyc);
    end
  endtask

  // Monitor: every completion pops the scoreboard; idle ports must read 0.
  always @(negedge clk) begin
    if ((a_read[0] | a_write[0]) && !a_wait[0]) check_pop(0, a_rdata);
    else check_zero("a_data_idle", a_rdata);
    for (int p = 0; p < 2; p++) begin
      if ((b_read[p] | b_write[p]) && !b_wait[p]) check_pop(p + 1, b_rdata[p*32 +: 32]);
      else check_zero("b_data_idle", b_rdata[p*32 +: 32]);
    end
  end

  task automatic check_vec(input string name, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    // In reset, a request sees wait == request and no data.
    drive(2, 1'b1, 1'b0, 1'b0, 32'd11, 32'd0);
    @(negedge clk);
    check_vec("reset_b_wait", b_wait, 2'b10);
    check_vec("reset_a_wait", {1'b0, a_wait[0]}, 2'b00);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single port, LATENCY = 1.
    access("a_wr3",     0, 1'b1, 1'b0, 32'd3,   32'hC,  32'h0,  1);
    access("a_rd3",     0, 1'b0, 1'b0, 32'd3,   32'h0,  32'hC,  1);
    access("a_wr0",     0, 1'b1, 1'b0, 32'd0,   32'h11, 32'h0,  1);
    access("a_wr_oor",  0, 1'b1, 1'b0, 32'd256, 32'h55, 32'h0,  1);
    access("a_rd_oor",  0, 1'b0, 1'b0, 32'd256, 32'h0,  32'h0,  1);
    access("a_rd0",     0, 1'b0, 1'b0, 32'd0,   32'h0,  32'h11, 1);
    // en low for 4 cycles while BUSY delays completion by 4.
    fork
      access("a_en_stall", 0, 1'b0, 1'b0, 32'd3, 32'h0, 32'hC, 5);
      begin
        @(posedge clk); #1; en = 1'b0;
        repeat (4) @(posedge clk);
        #1; en = 1'b1;
      end
    join

    // Two ports, LATENCY = 3, simultaneous from reset (ptr = 0).
    fork
      begin
        access("b_p0_first", 1, 1'b1, 1'b0, 32'd10, 32'hA0, 32'h0, 3);
        access("b_p0_again", 1, 1'b1, 1'b0, 32'd12, 32'hC2, 32'h0, 7);
      end
      access("b_p1_second", 2, 1'b1, 1'b0, 32'd11, 32'hB1, 32'h0, 7);
    join
    // ptr now points at port 1, so port 1 goes first.
    fork
      access("b_p0_rd10", 1, 1'b0, 1'b0, 32'd10, 32'h0, 32'hA0, 7);
      access("b_p1_rd11", 2, 1'b0, 1'b0, 32'd11, 32'h0, 32'hB1, 3);
    join

    // LR/SC success.
    access("b_init100", 1, 1'b1, 1'b0, 32'd100, 32'd1, 32'd0, 3);
    access("b_lr100",   1, 1'b0, 1'b1, 32'd100, 32'd0, 32'd1, 3);
    access("b_sc100",   1, 1'b1, 1'b1, 32'd100, 32'd5, 32'd0, 3);
    access("b_rd100",   1, 1'b0, 1'b0, 32'd100, 32'd0, 32'd5, 3);

    // LR/SC broken by another port's plain write.
    access("b_init200",  1, 1'b1, 1'b0, 32'd200, 32'd2, 32'd0, 3);
    access("b_lr200",    1, 1'b0, 1'b1, 32'd200, 32'd0, 32'd2, 3);
    access("b_p1_wr200", 2, 1'b1, 1'b0, 32'd200, 32'd9, 32'd0, 3);
    access("b_sc200",    1, 1'b1, 1'b1, 32'd200, 32'd7, SC_BREAK_RET, 3);
    access("b_rd200",    1, 1'b0, 1'b0, 32'd200, 32'd0, MEM200_EXP, 3);

    // Read at DEPTH returns 0 and completes normally.
    access("b_rd_oor", 2, 1'b0, 1'b0, 32'd256, 32'd0, 32'd0, 3);

    // Leave ptr at port 1, then reset mid-BUSY: port 0 wins afterwards.
    access("b_rd12", 1, 1'b0, 1'b0, 32'd12, 32'd0, 32'hC2, 3);
    fork
      access("b_rst_p0", 1, 1'b0, 1'b0, 32'd10, 32'd0, 32'hA0, 6);
      access("b_rst_p1", 2, 1'b0, 1'b0, 32'd11, 32'd0, 32'hB1, 10);
      begin
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        check_vec("rst_mid_b_wait", b_wait, 2'b11);
        @(posedge clk);
        #1; rst = 1'b0;
      end
    join

    repeat (2) @(posedge clk);
    n_checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q0.size() + q1.size() + q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_data_ram.md
# shared_data_ram

Parametrised, multi-port successor to the single-port dummy data RAM used by the core benches. It serves `N_PORTS` cores over the existing `mem_*` request/wait interface, with:
- round-robin arbitration;
- a configurable number of wait-state cycles;
- per-port load-reserved/store-conditional reservations backing the atomic load/store instructions.

It sits between the cores' memory stages and the shared data store in multicore builds and benches.

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `ADDR_W`, 32: word address width.
- `DEPTH`, 1024: number of words implemented.
- `N_PORTS`, 2: number of core ports, 1..8.
- `LATENCY`, 1: wait cycles per access, ≥1.

Ports (per-port signals are flattened; port p occupies slice p):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable; low freezes all state.
- `mem_addr`  in  N_PORTS*ADDR_W  word address.
- `mem_data_w`  in  N_PORTS*DATA_W  write data.
- `mem_read`  in  N_PORTS  read request.
- `mem_write`  in  N_PORTS  write request.
- `mem_atomic`  in  N_PORTS  qualifies the request as LOAD_A / STORE_A.
- `mem_data_r`  out  N_PORTS*DATA_W  read data or store-conditional status.
- `mem_wait`  out  N_PORTS  stall; low marks the completion cycle.

## Operation
- **Request.** Port p requests when `mem_read[p] | mem_write[p]`. If both are high, the request is a write.
- **Stability.** Address, data and atomic must stay stable while `mem_wait[p]` is high.
- **Wait signal.** `mem_wait[p] = req[p] & ~complete[p]`, combinational. A non-requesting port has `mem_wait` = 0.
- **FSM states.**
  - IDLE: if any request is present, grant the round-robin winner, load `cnt = LATENCY-1`, go to BUSY.
  - BUSY, `cnt != 0`: decrement `cnt`.
  - BUSY, `cnt == 0`: complete the granted port, then return to IDLE.
- **Arbitration.**
  - Scan starts at `ptr` and proceeds upward, modulo `N_PORTS`.
  - On each grant, `ptr` becomes grant+1.
  - Reset value of `ptr` is 0.
- **Completion cycle.**
  - Read: `mem_data_r[p] = data[addr]`, asynchronous array read.
  - Write: `data[addr]` is updated at the edge ending the cycle.
- **Data output default.** `mem_data_r[p]` is 0 in every cycle that is not p's completing read or store-conditional.
- **Out of range.** For `addr >= DEPTH`, reads return 0, writes are dropped, and the request still completes normally.
- **Withdrawn request.** If the granted port drops its request while BUSY (protocol violation), the access aborts: no write, no reservation change, return to IDLE.
- **`en` low.**
  - State, counter, pointer, memory and reservations hold.
  - No completion occurs.
  - `mem_wait` = request for every port.
- **Reset (including mid-access).**
  - Asynchronously forces IDLE, `cnt` = 0, `ptr` = 0, and clears all reservations.
  - Memory contents are not cleared.
  - Outputs during reset: `mem_data_r` = 0, `mem_wait` = request.

## Timing
- Request presented in cycle 0 against an IDLE FSM: `mem_wait` is high in cycles 0..LATENCY-1 and low in cycle LATENCY.
  - With `LATENCY` = 1: one wait cycle, then completion.
- After a completion the FSM spends one IDLE cycle. Throughput is one access per `LATENCY+1` cycles.
- A contending port waits an additional `LATENCY+1` cycles per access served ahead of it.
- Reservation and memory updates are visible to an access arbitrated in the next IDLE cycle.

## Configuration
- `SHARED_RAM_ATOMIC_EN` defined:
  - Each port has a reservation {valid, addr}.
  - Completed LOAD_A sets that port's reservation to `addr`.
  - Completed STORE_A succeeds iff the port's reservation is valid and its address matches.
    - On success: write performed, `mem_data_r` = 0, own reservation cleared.
    - On failure: no write, `mem_data_r` = 1, own reservation cleared.
  - Any completed write (plain or successful conditional) clears every port's reservation whose address equals `addr`.
- `SHARED_RAM_ATOMIC_EN` not defined:
  - `mem_atomic` is ignored and no reservation storage exists.
  - STORE_A acts as a plain store and returns `mem_data_r` = 0.

## Structure
- Package `shared_ram_pkg` holds:
  - FSM state encoding (IDLE, BUSY);
  - store-conditional status constants: `SC_OK` = 0, `SC_FAIL` = 1.
- One sub-module, `rr_arbiter`: `N_PORTS` request vector plus `ptr` in, one-hot grant and index out. Purely combinational; the pointer register lives in the parent.

## Test plan
- **Single port, `LATENCY` = 1.**
  - Stimulus: port 0 writes 0xC to addr 3, then reads addr 3.
  - Required: each access shows 1 wait cycle; the read returns 0xC.
- **`LATENCY` = 3, two ports request in the same cycle.**
  - Stimulus: from reset, both ports request simultaneously.
  - Required: port 0 completes in cycle 3 and port 1 in cycle 7. On the next simultaneous request, port 1 is served first.
- **LR/SC success.**
  - Stimulus: port 0 LOAD_A addr 100 (holding 1), then STORE_A 5 to addr 100.
  - Required: the LOAD_A returns 1, the STORE_A returns 0, and memory[100] = 5.
- **LR/SC break.**
  - Stimulus: port 0 LOAD_A addr 200; port 1 plain write 9 to addr 200; port 0 STORE_A 7 to addr 200.
  - Required: the STORE_A returns 1 and memory[200] = 9. Without the macro, the same sequence returns 0 and leaves memory[200] = 7.
- **Boundary conditions.**
  - Read of addr `DEPTH`: returns 0 and completes normally.
  - `rst` pulse in mid-BUSY: `mem_wait` equals the request, and the access re-arbitrates from IDLE with `ptr` = 0.
  - `en` low for 4 cycles mid-access: completion is delayed by exactly 4 cycles.
